// File: rtl/GLOBALS.sv
// Shared fixed-point definitions: coefficient quantization and product dequantization.
package GLOBALS;

    localparam int QUANT_BITS = 10;
    localparam int DEQ_W      = 128;

    // Callers sign-extend their full-width product to DEQ_W and truncate the result.
    function automatic logic signed [DEQ_W-1:0] deq(input logic signed [DEQ_W-1:0] prod);
        return prod >>> QUANT_BITS;
    endfunction

endpackage

// File: rtl/fir_interp_mac.sv
// Registered multiply-dequantize-accumulate with wrap-around accumulation.
module fir_interp_mac
    import GLOBALS::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] coeff,
    input  logic signed [DATA_WIDTH-1:0] sample,
    output logic signed [DATA_WIDTH-1:0] acc
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]         prod;
    logic signed [DATA_WIDTH-1:0] term;

    assign prod = PW'(coeff) * PW'(sample);
    assign term = DATA_WIDTH'(deq(DEQ_W'(prod)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + term;
        end
    end

endmodule

// File: rtl/fir_interp.sv
// Polyphase interpolating FIR: one input sample yields INTERPOLATION outputs,
// each computed with one serial MAC per tap of its phase.
module fir_interp
    import GLOBALS::*;
#(
    parameter int INTERPOLATION = 2,
    parameter int TAPS          = 32,
    parameter int DATA_WIDTH    = 32,
    parameter logic signed [TAPS-1:0][DATA_WIDTH-1:0] COEFF = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         x_in_rd_en,
    input  logic                         x_in_empty,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    output logic signed [DATA_WIDTH-1:0] y_out,
    output logic                         y_out_wr_en,
    input  logic                         y_out_full
);

    localparam int L      = INTERPOLATION;
    localparam int P      = TAPS / INTERPOLATION;
    localparam int K_W    = $clog2(P + 1);
    localparam int PH_W   = $clog2(L + 1);
    localparam int IDX_W  = $clog2(TAPS + 1);

    if (INTERPOLATION < 1 || INTERPOLATION > 64) begin : g_bad_interp
        $error("fir_interp: INTERPOLATION must be in 1..64");
    end
    if (TAPS % INTERPOLATION != 0) begin : g_bad_taps
        $error("fir_interp: TAPS must be a multiple of INTERPOLATION");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > DEQ_W / 2) begin : g_bad_width
        $error("fir_interp: DATA_WIDTH out of range for the dequantizer");
    end

    typedef enum logic [1:0] {
        LOAD,
        MAC,
        OUTPUT
    } state_t;

    state_t                       state_q, state_d;
    logic [K_W-1:0]               k_q, k_d;
    logic [PH_W-1:0]              phase_q, phase_d;
    logic signed [DATA_WIDTH-1:0] sd_q [P];
    logic                         shift;
    logic                         mac_clear;
    logic                         mac_en;
    logic [IDX_W-1:0]             coeff_idx;
    logic signed [DATA_WIDTH-1:0] coeff_sel;
    logic signed [DATA_WIDTH-1:0] sample_sel;
    logic signed [DATA_WIDTH-1:0] acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            k_q     <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            phase_q <= phase_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < P; i++) sd_q[i] <= '0;
        end else if (shift) begin
            sd_q[0] <= x_in;
            for (int i = 1; i < P; i++) sd_q[i] <= sd_q[i-1];
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        phase_d     = phase_q;
        shift       = 1'b0;
        mac_clear   = 1'b0;
        mac_en      = 1'b0;
        x_in_rd_en  = 1'b0;
        y_out_wr_en = 1'b0;
        y_out       = '0;
        case (state_q)
            LOAD: begin
                if (!x_in_empty) begin
                    x_in_rd_en = 1'b1;
                    shift      = 1'b1;
                    phase_d    = '0;
                    k_d        = '0;
                    mac_clear  = 1'b1;
                    state_d    = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (k_q == K_W'(P - 1)) state_d = OUTPUT;
                else                    k_d     = k_q + K_W'(1);
            end
            OUTPUT: begin
                y_out = acc;
                // While stalled the accumulator must survive so y_out stays stable.
                if (!y_out_full) begin
                    y_out_wr_en = 1'b1;
                    mac_clear   = 1'b1;
                    k_d         = '0;
                    if (phase_q == PH_W'(L - 1)) begin
                        state_d = LOAD;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                        state_d = MAC;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign coeff_idx = IDX_W'(k_q) * IDX_W'(L) + IDX_W'(phase_q);

    always_comb begin
        coeff_sel  = '0;
        sample_sel = '0;
        for (int i = 0; i < TAPS; i++) begin
            if (coeff_idx == IDX_W'(i)) coeff_sel = COEFF[i];
        end
        for (int i = 0; i < P; i++) begin
            if (k_q == K_W'(i)) sample_sel = sd_q[i];
        end
    end

    fir_interp_mac #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (mac_clear),
        .en    (mac_en),
        .coeff (coeff_sel),
        .sample(sample_sel),
        .acc   (acc)
    );

endmodule
